dmem_responder: RTL

- Memory-side responder for the CPU data-memory request interface. Accepts one request at a time: read, write, load-link or store-conditional.
- Applies programmable wait states and returns read data plus store-conditional status over a valid/ready response channel.
- Holds the LL/SC reservation on the memory side.
- Replaces the zero-latency d_memory so the pipeline can be verified against a multi-cycle memory.

---
 rtl/dmem_pkg.sv | 46 ++++
 rtl/dmem_responder_link_monitor.sv | 36 +++
 rtl/dmem_responder.sv | 117 +++++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory responder: FSM states,
// decoded request opcodes, the byte-lane merge used by writes, and the
// request decoder.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } dmem_state_t;

  typedef enum logic [2:0] {
    OP_RD,
    OP_WR,
    OP_LL,
    OP_SC,
    OP_ILLEGAL
  } dmem_op_t;

  // Merge new_word into old_word lane by lane; an all-zero enable means
  // a full-word write.
  function automatic logic [31:0] byte_merge(input logic [31:0] old_word,
                                             input logic [31:0] new_word,
                                             input logic [3:0]  byte_en);
    logic [3:0]  en;
    logic [31:0] merged;
    en = (byte_en == 4'b0000) ? 4'b1111 : byte_en;
    for (int i = 0; i < 4; i++) begin
      merged[8*i +: 8] = en[i] ? new_word[8*i +: 8] : old_word[8*i +: 8];
    end
    return merged;
  endfunction

  // Load-link and store-conditional together is meaningless; SC takes
  // precedence over the read/write bit, LL always reads.
  function automatic dmem_op_t decode_op(input logic rw_,
                                         input logic load_link_,
                                         input logic check_link);
    if (!load_link_ && check_link) return OP_ILLEGAL;
    else if (check_link)           return OP_SC;
    else if (!load_link_)          return OP_LL;
    else if (!rw_)                 return OP_WR;
    else                           return OP_RD;
  endfunction

endpackage

// File: rtl/dmem_responder_link_monitor.sv
// LL/SC reservation holder: one reserved word address plus a valid flag.
// hit reports that addr matches a live reservation.
module link_monitor
  import dmem_pkg::*;
#(
  parameter int BITS = 32
) (
  input  logic            clk,
  input  logic            rst_,
  input  logic            set,
  input  logic            clear,
  input  logic            write_hit_check,
  input  logic [BITS-1:0] addr,
  output logic            hit
);

  logic            link_valid;
  logic [BITS-1:0] link_addr;

  assign hit = link_valid && (addr == link_addr);

  // Reservation register: cleared by SC or a write to the reserved word,
  // armed by a load-link.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      link_valid <= 1'b0;
      link_addr  <= '0;
    end else if (clear || (write_hit_check && hit)) begin
      link_valid <= 1'b0;
    end else if (set) begin
      link_valid <= 1'b1;
      link_addr  <= addr;
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder. Accepts one request at a time,
// commits the memory operation at acceptance, then presents a registered
// response after WAIT_STATES extra cycles on a valid/ready channel.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int              BITS        = 32,
  parameter int              WORDS       = 256,
  parameter logic [BITS-1:0] BASE_ADDR   = '0,
  parameter int              WAIT_STATES = 2
) (
  input  logic            clk,
  input  logic            rst_,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [BITS-1:0] req_addr,
  input  logic [BITS-1:0] req_wdata,
  input  logic            req_rw_,
  input  logic [3:0]      req_byte_en,
  input  logic            req_load_link_,
  input  logic            req_check_link,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [BITS-1:0] rsp_rdata,
  output logic            rsp_sc_ok,
  output logic            rsp_err
);

  localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int WC_W  = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
  localparam logic [WC_W-1:0] WC_LOAD =
    (WAIT_STATES > 0) ? WC_W'(WAIT_STATES - 1) : '0;

  dmem_state_t     state, state_nxt;
  logic [WC_W-1:0] wait_cnt;

  logic [BITS-1:0] mem [WORDS];

  dmem_op_t        op;
  logic            accept;
  logic [BITS-1:0] offset;
  logic [IDX_W-1:0] mem_idx;
  logic            in_range;
  logic            link_hit;
  logic            is_err;
  logic            sc_ok;
  logic            do_write;
  logic            do_read;

  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);
  assign accept    = req_valid && req_ready;

  assign op       = decode_op(req_rw_, req_load_link_, req_check_link);
  assign offset   = req_addr - BASE_ADDR;
  assign mem_idx  = offset[IDX_W-1:0];
  assign in_range = (req_addr >= BASE_ADDR) && (offset < BITS'(WORDS));
  assign is_err   = !in_range || (op == OP_ILLEGAL);
  assign sc_ok    = in_range && (op == OP_SC) && link_hit;
  assign do_read  = in_range && ((op == OP_RD) || (op == OP_LL));
  assign do_write = accept && in_range && ((op == OP_WR) || sc_ok);

  link_monitor #(
    .BITS(BITS)
  ) u_link (
    .clk            (clk),
    .rst_           (rst_),
    .set            (accept && in_range && (op == OP_LL)),
    .clear          (accept && (op == OP_SC)),
    .write_hit_check(accept && in_range && (op == OP_WR)),
    .addr           (req_addr),
    .hit            (link_hit)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) state <= IDLE;
    else       state <= state_nxt;
  end

  // FSM next-state: accept in IDLE, count down in WAIT, hold in RESP.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (accept) state_nxt = (WAIT_STATES > 0) ? WAIT : RESP;
      WAIT: if (wait_cnt == '0) state_nxt = RESP;
      RESP: if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Wait-state counter, loaded at acceptance and run down in WAIT.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_)                                 wait_cnt <= '0;
    else if (accept)                           wait_cnt <= WC_LOAD;
    else if (state == WAIT && wait_cnt != '0)  wait_cnt <= wait_cnt - 1'b1;
  end

  // Memory array: write commits at the acceptance edge; not reset.
  always_ff @(posedge clk) begin
    if (do_write) mem[mem_idx] <= byte_merge(mem[mem_idx], req_wdata, req_byte_en);
  end

  // Response registers captured at acceptance and held until consumed.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      rsp_rdata <= '0;
      rsp_sc_ok <= 1'b0;
      rsp_err   <= 1'b0;
    end else if (accept) begin
      rsp_rdata <= do_read ? mem[mem_idx] : '0;
      rsp_sc_ok <= sc_ok;
      rsp_err   <= is_err;
    end
  end

endmodule
